// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory access arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CORE_BUSY = 2'd1,
        ST_DMA_BUSY  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/dmem_lane_formatter.sv
// rtl/dmem_lane_formatter.sv - byte lane enables, store replication, load extension, misalign check
module dmem_lane_formatter
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_sh;

    always_comb begin
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: misalign_o = 1'b0;
            F3_LH, F3_LHU: misalign_o = lane_i[0];
            F3_LW:         misalign_o = (lane_i != 2'b00);
            default:       misalign_o = 1'b1;
        endcase

        // Loads always fetch the full word; lane selection happens on the way back.
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (we_i) begin
            case (funct3_i)
                F3_SB: begin
                    be_o    = 4'b0001 << lane_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o    = 4'b0011 << lane_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_sh = rdata_i >> {rsp_lane_i, 3'b000};
        case (rsp_funct3_i)
            F3_LB:   rdata_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            F3_LH:   rdata_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            F3_LBU:  rdata_o = {24'h000000, rdata_sh[7:0]};
            F3_LHU:  rdata_o = {16'h0000, rdata_sh[15:0]};
            default: rdata_o = rdata_sh;
        endcase
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - core/DMA arbiter and handshake sequencer for the shared data memory
module dmem_access_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [2:0]  core_funct3_i,
    output logic        core_stall_o,
    output logic [31:0] core_rdata_o,
    output logic        core_done_o,
    output logic        core_err_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,
    output logic        dma_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e      state_q, state_d;
    owner_e      last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [2:0]  rsp_funct3_q, rsp_funct3_d;
    logic [1:0]  rsp_lane_q, rsp_lane_d;

    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic        fmt_misalign;
    logic [31:0] fmt_rdata;

    logic idle, core_bad, core_win, dma_win, ack_v, timeout, busy_end;

    dmem_lane_formatter u_fmt (
        .we_i         (core_we_i),
        .funct3_i     (core_funct3_i),
        .lane_i       (core_addr_i[1:0]),
        .wdata_i      (core_wdata_i),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .misalign_o   (fmt_misalign),
        .rsp_funct3_i (rsp_funct3_q),
        .rsp_lane_i   (rsp_lane_q),
        .rdata_i      (mem_rdata_i),
        .rdata_o      (fmt_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DMA;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rsp_funct3_q <= '0;
            rsp_lane_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            rsp_funct3_q <= rsp_funct3_d;
            rsp_lane_q   <= rsp_lane_d;
        end
    end

    // A misaligned core access is answered locally and never competes for memory.
    assign idle     = (state_q == ST_IDLE);
    assign core_bad = idle & core_req_i & fmt_misalign;
    assign core_win = idle & core_req_i & ~fmt_misalign & (~dma_req_i | (last_owner_q == OWN_DMA));
    assign dma_win  = idle & dma_req_i & ~core_win;
    assign ack_v    = mem_ack_i & mem_req_q;
    assign timeout  = ~idle & ~ack_v & (cnt_q == CW'(MAX_WAIT));
    assign busy_end = ~idle & (ack_v | timeout);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        rsp_funct3_d = rsp_funct3_q;
        rsp_lane_d   = rsp_lane_q;
        if (idle) begin
            cnt_d = '0;
            if (core_win) begin
                state_d      = ST_CORE_BUSY;
                last_owner_d = OWN_CORE;
                mem_req_d    = 1'b1;
                mem_we_d     = core_we_i;
                mem_addr_d   = {core_addr_i[31:2], 2'b00};
                mem_wdata_d  = fmt_wdata;
                mem_be_d     = fmt_be;
                rsp_funct3_d = core_funct3_i;
                rsp_lane_d   = core_addr_i[1:0];
            end else if (dma_win) begin
                state_d      = ST_DMA_BUSY;
                last_owner_d = OWN_DMA;
                mem_req_d    = 1'b1;
                mem_we_d     = dma_we_i;
                mem_addr_d   = dma_addr_i & 32'hFFFF_FFFC;
                mem_wdata_d  = dma_wdata_i;
                mem_be_d     = 4'b1111;
            end
        end else if (busy_end) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            cnt_d     = '0;
        end else if (cnt_q != CW'(MAX_WAIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Combinational responses are forced low while reset is held.
    always_comb begin
        core_done_o  = 1'b0;
        core_err_o   = 1'b0;
        core_rdata_o = '0;
        core_stall_o = 1'b0;
        dma_gnt_o    = 1'b0;
        dma_rvalid_o = 1'b0;
        dma_err_o    = 1'b0;
        dma_rdata_o  = '0;
        if (!rst_i) begin
            core_done_o  = core_bad | ((state_q == ST_CORE_BUSY) & busy_end);
            core_err_o   = core_bad | ((state_q == ST_CORE_BUSY) & timeout);
            core_rdata_o = ((state_q == ST_CORE_BUSY) & ack_v & ~mem_we_q) ? fmt_rdata : '0;
            core_stall_o = core_req_i & ~core_done_o;
            dma_gnt_o    = dma_win;
            dma_rvalid_o = (state_q == ST_DMA_BUSY) & busy_end;
            dma_err_o    = (state_q == ST_DMA_BUSY) & timeout;
            dma_rdata_o  = ((state_q == ST_DMA_BUSY) & ack_v) ? mem_rdata_i : '0;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb/tb_dmem_access_arbiter.sv - directed self-checking bench for dmem_access_arbiter
module tb_dmem_access_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [2:0]  core_funct3_i;
    logic        core_stall_o, core_done_o, core_err_o;
    logic [31:0] core_rdata_o;
    logic        dma_req_i, dma_we_i;
    logic [31:0] dma_addr_i, dma_wdata_i;
    logic        dma_gnt_o, dma_rvalid_o, dma_err_o;
    logic [31:0] dma_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_mis = 0;
    int gnt_count = 0;

    dmem_access_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_funct3_i (core_funct3_i),
        .core_stall_o  (core_stall_o),
        .core_rdata_o  (core_rdata_o),
        .core_done_o   (core_done_o),
        .core_err_o    (core_err_o),
        .dma_req_i     (dma_req_i),
        .dma_we_i      (dma_we_i),
        .dma_addr_i    (dma_addr_i),
        .dma_wdata_i   (dma_wdata_i),
        .dma_gnt_o     (dma_gnt_o),
        .dma_rvalid_o  (dma_rvalid_o),
        .dma_rdata_o   (dma_rdata_o),
        .dma_err_o     (dma_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {22'd0, core_stall_o, core_done_o, core_err_o, dma_gnt_o, dma_rvalid_o,
                dma_err_o, mem_req_o, mem_we_o, mem_be_o[1:0]} | {28'd0, mem_be_o};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, ctl_vec(), 32'd0);
        check({tag, "_core_rdata"}, core_rdata_o, 32'd0);
        check({tag, "_dma_rdata"}, dma_rdata_o, 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h101; core_wdata_i = 32'h0;
        core_funct3_i = 3'b010;
        dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h0; dma_wdata_i = 32'h0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;

        // Reset: every output low even with requests pending
        tick();
        tick();
        check_quiet("reset");
        rst_i = 1'b0;
        core_req_i = 1'b0; dma_req_i = 1'b0;
        tick();

        // Core LW 0x100, ack after three wait cycles
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h100; core_funct3_i = 3'b010;
        #1;
        check("lw_idle_stall", core_stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_wait_req", mem_req_o, 1);
            check("lw_wait_stall", core_stall_o, 1);
        end
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        check("lw_done", core_done_o, 1);
        check("lw_err", core_err_o, 0);
        check("lw_stall_release", core_stall_o, 0);
        check("lw_rdata", core_rdata_o, 32'hDEADBEEF);
        check("lw_be", mem_be_o, 4'b1111);
        check("lw_addr", mem_addr_o, 32'h100);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("lw_req_cleared", mem_req_o, 0);

        // Core LB / LBU at 0x103
        core_funct3_i = 3'b000; core_addr_i = 32'h103;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h80112233;
        #1;
        check("lb_rdata", core_rdata_o, 32'hFFFFFF80);
        check("lb_addr", mem_addr_o, 32'h100);
        tick();
        mem_ack_i = 1'b0; core_funct3_i = 3'b100;
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("lbu_rdata", core_rdata_o, 32'h00000080);
        tick();
        mem_ack_i = 1'b0; core_req_i = 1'b0;

        // Core SH at 0x202
        core_req_i = 1'b1; core_we_i = 1'b1; core_funct3_i = 3'b001;
        core_addr_i = 32'h202; core_wdata_i = 32'h0000ABCD;
        tick();
        check("sh_be", mem_be_o, 4'b1100);
        check("sh_wdata", mem_wdata_o, 32'hABCDABCD);
        check("sh_addr", mem_addr_o, 32'h200);
        check("sh_we", mem_we_o, 1);
        mem_ack_i = 1'b1;
        #1;
        check("sh_done", core_done_o, 1);
        check("sh_rdata_zero", core_rdata_o, 32'h0);
        tick();
        mem_ack_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0;

        // Misaligned LW at 0x101 and illegal funct3 011
        core_req_i = 1'b1; core_funct3_i = 3'b010; core_addr_i = 32'h101;
        #1;
        check("mis_err", core_err_o, 1);
        check("mis_done", core_done_o, 1);
        check("mis_stall", core_stall_o, 0);
        check("mis_rdata", core_rdata_o, 32'h0);
        tick();
        check("mis_no_req", mem_req_o, 0);
        core_funct3_i = 3'b011; core_addr_i = 32'h100;
        #1;
        check("ill_err", core_err_o, 1);
        tick();
        check("ill_no_req", mem_req_o, 0);
        core_req_i = 1'b0;

        // Both requesting from reset: core, DMA, core, DMA
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b0; core_funct3_i = 3'b010; core_addr_i = 32'h10;
        dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h20;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("arb_gnt", dma_gnt_o, (g % 2));
            gnt_count += int'(dma_gnt_o);
            tick();
            check("arb_addr", mem_addr_o, (g % 2) ? 32'h20 : 32'h10);
            check("arb_stall", core_stall_o, 1);
            mem_ack_i = 1'b1; mem_rdata_i = 32'h1000 + g;
            #1;
            check("arb_core_done", core_done_o, (g % 2) ? 0 : 1);
            check("arb_dma_rvalid", dma_rvalid_o, (g % 2));
            if (g % 2 == 1) check("arb_dma_rdata", dma_rdata_o, 32'h1000 + g);
            tick();
            mem_ack_i = 1'b0;
            #1;
        end
        check("arb_gnt_count", gnt_count, 2);
        core_req_i = 1'b0; dma_req_i = 1'b0;

        // DMA read that never gets an ack
        dma_req_i = 1'b1; dma_addr_i = 32'h47; mem_rdata_i = 32'hCAFEF00D;
        #1;
        check("to_gnt", dma_gnt_o, 1);
        tick();
        dma_req_i = 1'b0;
        check("to_addr", mem_addr_o, 32'h44);
        check("to_be", mem_be_o, 4'b1111);
        for (int i = 0; i < 15; i++) begin
            check("to_wait", {mem_req_o, dma_rvalid_o, dma_err_o}, 3'b100);
            tick();
        end
        check("to_err", dma_err_o, 1);
        check("to_rvalid", dma_rvalid_o, 1);
        check("to_rdata", dma_rdata_o, 32'h0);
        tick();
        check("to_req_drop", mem_req_o, 0);
        check("to_idle_err", dma_err_o, 0);

        // Reset in the middle of a core access
        core_req_i = 1'b1; core_funct3_i = 3'b010; core_addr_i = 32'h300;
        tick();
        check("rst_busy_req", mem_req_o, 1);
        rst_i = 1'b1; mem_ack_i = 1'b1;
        #1;
        check_quiet("rst_mid");
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_after_done", core_done_o, 0);
        check("rst_after_req", mem_req_o, 0);
        check("rst_after_stall", core_stall_o, 1);
        mem_ack_i = 1'b0;
        tick();
        check("rst_reissue", mem_req_o, 1);
        check("rst_reissue_addr", mem_addr_o, 32'h300);
        core_req_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
